// File: rtl/id_pkg.sv
// Shared decode constants for the 16-bit, 8-register core: opcodes,
// instruction field positions, the NOP word and the ALU-op encoding used by EX.
package id_pkg;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_SL   = 4'd6;
   localparam logic [3:0] OP_SR   = 4'd7;
   localparam logic [3:0] OP_ADDI = 4'd9;
   localparam logic [3:0] OP_LD   = 4'd10;
   localparam logic [3:0] OP_ST   = 4'd11;
   localparam logic [3:0] OP_BR   = 4'd12;

   localparam int OP_HI  = 15;
   localparam int OP_LO  = 12;
   localparam int RD_HI  = 11;
   localparam int RD_LO  = 9;
   localparam int RS1_HI = 8;
   localparam int RS1_LO = 6;
   localparam int RS2_HI = 5;
   localparam int RS2_LO = 3;
   localparam int IMM_HI = 5;
   localparam int IMM_LO = 0;

   localparam logic [15:0] NOP_INSTR = 16'h0000;

   // ALU ops share their values with the matching register-register opcodes.
   typedef enum logic [3:0] {
      ALU_NOP = 4'd0,
      ALU_ADD = 4'd1,
      ALU_SUB = 4'd2,
      ALU_AND = 4'd3,
      ALU_OR  = 4'd4,
      ALU_XOR = 4'd5,
      ALU_SL  = 4'd6,
      ALU_SR  = 4'd7
   } alu_op_e;

endpackage

// File: rtl/id_stage_reg_file.sv
// 8 x DW register file: R0 hard-zero, two combinational read ports, one write port.
// Optional same-cycle write-to-read bypass under ID_RF_BYPASS_EN.
module reg_file #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [2:0]    waddr,
   input  logic [DW-1:0] wdata,
   input  logic [2:0]    raddr_a,
   input  logic [2:0]    raddr_b,
   output logic [DW-1:0] rdata_a,
   output logic [DW-1:0] rdata_b
);

   logic [DW-1:0] regs_q [8];
   logic [DW-1:0] regs_d [8];

   // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      regs_d = regs_q;
      if (we && waddr != 3'd0) regs_d[waddr] = wdata;
   end

   // NOTE: this array lives in flops and must clear on reset, so it is reset explicitly
   // (a RAM macro could not be); state updates use non-blocking assignments.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   always_comb begin
      rdata_a = regs_q[raddr_a];
      rdata_b = regs_q[raddr_b];
`ifdef ID_RF_BYPASS_EN
      if (we && waddr != 3'd0 && waddr == raddr_a) rdata_a = wdata;
      if (we && waddr != 3'd0 && waddr == raddr_b) rdata_b = wdata;
`endif
   end

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID register, register file, branch resolution, hazard detection
// and the ID/EX register. ID_RF_BYPASS_EN enables the register-file write bypass.
module id_stage
   import id_pkg::*;
#(
   parameter int DW  = 8,
   parameter int PCW = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [PCW-1:0] if_pc,
   input  logic [15:0]    if_instr,
   input  logic           wb_we,
   input  logic [2:0]     wb_dest,
   input  logic [DW-1:0]  wb_data,
   output logic           stall,
   output logic           branch_taken,
   output logic [5:0]     branch_offset_imm,
   output logic [3:0]     id_ex_alu_op,
   output logic [DW-1:0]  id_ex_val1,
   output logic [DW-1:0]  id_ex_val2,
   output logic [DW-1:0]  id_ex_st_data,
   output logic [2:0]     id_ex_dest,
   output logic           id_ex_reg_write,
   output logic           id_ex_mem_read,
   output logic           id_ex_mem_write
);

   typedef struct packed {
      alu_op_e       alu_op;
      logic [DW-1:0] val1;
      logic [DW-1:0] val2;
      logic [DW-1:0] st_data;
      logic [2:0]    dest;
      logic          reg_write;
      logic          mem_read;
      logic          mem_write;
   } id_ex_t;

   logic [15:0]    instr_q, instr_d;
   logic [PCW-1:0] pc_q, pc_d;
   id_ex_t         ex_q, ex_d;

   logic [3:0]    op;
   logic [2:0]    rd, rs1, rs2, raddr_b;
   logic [5:0]    imm;
   logic [DW-1:0] rdata_a, rdata_b, imm_sext;
   logic          is_alu, is_imm, is_br, use_rs1, use_rs2, use_rd;
   logic          load_use, br_hazard;
   logic          pc_unused;

   assign op       = instr_q[OP_HI:OP_LO];
   assign rd       = instr_q[RD_HI:RD_LO];
   assign rs1      = instr_q[RS1_HI:RS1_LO];
   assign rs2      = instr_q[RS2_HI:RS2_LO];
   assign imm      = instr_q[IMM_HI:IMM_LO];
   assign imm_sext = {{(DW-6){imm[5]}}, imm};
   // The ID pc is carried for downstream debug only; fetch computes branch targets.
   assign pc_unused = ^pc_q;

   assign is_alu  = (op >= OP_ADD) && (op <= OP_SR);
   assign is_imm  = (op == OP_ADDI) || (op == OP_LD) || (op == OP_ST);
   assign is_br   = (op == OP_BR);
   assign use_rs1 = is_alu || is_imm || is_br;
   assign use_rs2 = is_alu;
   assign use_rd  = (op == OP_ST);
   assign raddr_b = use_rd ? rd : rs2;

   reg_file #(.DW(DW)) u_reg_file (
      .clk     (clk),
      .rst     (rst),
      .we      (wb_we),
      .waddr   (wb_dest),
      .wdata   (wb_data),
      .raddr_a (rs1),
      .raddr_b (raddr_b),
      .rdata_a (rdata_a),
      .rdata_b (rdata_b)
   );

   assign load_use  = ex_q.mem_read && (ex_q.dest != 3'd0) &&
                      ((use_rs1 && ex_q.dest == rs1) ||
                       ((use_rs2 || use_rd) && ex_q.dest == raddr_b));
   assign br_hazard = is_br && ex_q.reg_write && (ex_q.dest != 3'd0) && (ex_q.dest == rs1);

   assign stall             = load_use || br_hazard;
   assign branch_taken      = is_br && (rdata_a == '0) && !stall;
   assign branch_offset_imm = imm;

   always_comb begin
      instr_d = instr_q;
      pc_d    = pc_q;
      if (!stall) begin
         instr_d = branch_taken ? NOP_INSTR : if_instr;
         pc_d    = if_pc;
      end
   end

   // BR, NOP and undefined opcodes all leave a bubble in ID/EX.
   always_comb begin
      ex_d = '0;
      if (!stall && (is_alu || is_imm)) begin
         ex_d.alu_op    = is_alu ? alu_op_e'(op) : ALU_ADD;
         ex_d.val1      = rdata_a;
         ex_d.val2      = is_alu ? rdata_b : imm_sext;
         ex_d.st_data   = use_rd ? rdata_b : '0;
         ex_d.dest      = rd;
         ex_d.reg_write = is_alu || (op == OP_ADDI) || (op == OP_LD);
         ex_d.mem_read  = (op == OP_LD);
         ex_d.mem_write = (op == OP_ST);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_q <= NOP_INSTR;
         pc_q    <= '0;
         ex_q    <= '0;
      end else begin
         instr_q <= instr_d;
         pc_q    <= pc_d;
         ex_q    <= ex_d;
      end
   end

   assign id_ex_alu_op    = ex_q.alu_op;
   assign id_ex_val1      = ex_q.val1;
   assign id_ex_val2      = ex_q.val2;
   assign id_ex_st_data   = ex_q.st_data;
   assign id_ex_dest      = ex_q.dest;
   assign id_ex_reg_write = ex_q.reg_write;
   assign id_ex_mem_read  = ex_q.mem_read;
   assign id_ex_mem_write = ex_q.mem_write;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios with literal expectations,
// then randomized traffic against an instruction-level reference model.
module tb_id_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  if_pc;
   logic [15:0] if_instr;
   logic        wb_we;
   logic [2:0]  wb_dest;
   logic [7:0]  wb_data;
   logic        stall, branch_taken;
   logic [5:0]  branch_offset_imm;
   logic [3:0]  id_ex_alu_op;
   logic [7:0]  id_ex_val1, id_ex_val2, id_ex_st_data;
   logic [2:0]  id_ex_dest;
   logic        id_ex_reg_write, id_ex_mem_read, id_ex_mem_write;

   always #5 clk = ~clk;

   id_stage #(.DW(8), .PCW(8)) dut (
      .clk               (clk),
      .rst               (rst),
      .if_pc             (if_pc),
      .if_instr          (if_instr),
      .wb_we             (wb_we),
      .wb_dest           (wb_dest),
      .wb_data           (wb_data),
      .stall             (stall),
      .branch_taken      (branch_taken),
      .branch_offset_imm (branch_offset_imm),
      .id_ex_alu_op      (id_ex_alu_op),
      .id_ex_val1        (id_ex_val1),
      .id_ex_val2        (id_ex_val2),
      .id_ex_st_data     (id_ex_st_data),
      .id_ex_dest        (id_ex_dest),
      .id_ex_reg_write   (id_ex_reg_write),
      .id_ex_mem_read    (id_ex_mem_read),
      .id_ex_mem_write   (id_ex_mem_write)
   );

   typedef struct packed {
      logic [3:0] alu;
      logic [7:0] v1, v2, sd;
      logic [2:0] dest;
      logic       rw, mr, mw;
   } ex_t;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: architectural registers, the instruction in decode,
   // and what the execute stage is expected to receive.
   logic [7:0]  m_rf [8];
   logic [15:0] m_ifid;
   ex_t         m_ex;

   logic        s_stall, s_bt;
   logic [5:0]  s_off;
   logic [7:0]  pc_cnt = 8'd0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic ex_t dut_ex();
      return {id_ex_alu_op, id_ex_val1, id_ex_val2, id_ex_st_data,
              id_ex_dest, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write};
   endfunction

   function automatic logic [7:0] mread(input logic [2:0] r);
      if (r == 3'd0) return 8'd0;
`ifdef ID_RF_BYPASS_EN
      if (wb_we && wb_dest == r) return wb_data;
`endif
      return m_rf[r];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_rf[i] = 8'd0;
      m_ifid = 16'h0000;
      m_ex   = '0;
   endtask

   // Evaluates the decode-stage instruction from its architectural meaning.
   task automatic model_eval(output logic st, output logic bt, output ex_t nx);
      int         op;
      logic [2:0] rd, rs1, rs2;
      logic [7:0] simm;
      logic [2:0] srcs [$];
      logic       issues;
      op   = int'(m_ifid[15:12]);
      rd   = m_ifid[11:9];
      rs1  = m_ifid[8:6];
      rs2  = m_ifid[5:3];
      simm = {{2{m_ifid[5]}}, m_ifid[5:0]};
      srcs = {};
      if (op >= 1 && op <= 7) srcs = {rs1, rs2};
      else if (op == 9 || op == 10) srcs = {rs1};
      else if (op == 11) srcs = {rs1, rd};
      else if (op == 12) srcs = {rs1};
      st = 1'b0;
      foreach (srcs[i])
         if (m_ex.mr && m_ex.dest != 3'd0 && m_ex.dest == srcs[i]) st = 1'b1;
      if (op == 12 && m_ex.rw && m_ex.dest != 3'd0 && m_ex.dest == rs1) st = 1'b1;
      bt = (op == 12) && (mread(rs1) == 8'd0) && !st;
      issues = !st && ((op >= 1 && op <= 7) || op == 9 || op == 10 || op == 11);
      nx = '0;
      if (issues) begin
         nx.alu  = (op <= 7) ? 4'(op) : 4'd1;
         nx.v1   = mread(rs1);
         nx.v2   = (op <= 7) ? mread(rs2) : simm;
         nx.sd   = (op == 11) ? mread(rd) : 8'd0;
         nx.dest = rd;
         nx.rw   = (op != 11);
         nx.mr   = (op == 10);
         nx.mw   = (op == 11);
      end
   endtask

   // One clock cycle: drive at negedge, check combinational outputs, advance the
   // model at posedge, check the ID/EX register at the following negedge.
   task automatic step(input logic [15:0] ins, input logic [2:0] wd,
                       input logic we, input logic [7:0] wdat);
      logic st_m, bt_m;
      ex_t  nx;
      if_instr = ins;
      if_pc    = pc_cnt;
      wb_we    = we;
      wb_dest  = wd;
      wb_data  = wdat;
      #1;
      model_eval(st_m, bt_m, nx);
      s_stall = stall;
      s_bt    = branch_taken;
      s_off   = branch_offset_imm;
      check("stall", 64'(s_stall), 64'(st_m));
      check("branch_taken", 64'(s_bt), 64'(bt_m));
      check("branch_offset_imm", 64'(s_off), 64'(m_ifid[5:0]));
      @(posedge clk);
      m_ex = nx;
      if (!st_m) m_ifid = bt_m ? 16'h0000 : ins;
      if (we && wd != 3'd0) m_rf[wd] = wdat;
      @(negedge clk);
      check("id_ex", 64'(dut_ex()), 64'(m_ex));
      pc_cnt++;
   endtask

   initial begin
      rst = 1'b1;
      if_instr = 16'h0000;
      if_pc = 8'd0;
      wb_we = 1'b0;
      wb_dest = 3'd0;
      wb_data = 8'd0;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset id_ex", 64'(dut_ex()), 64'd0);
      check("reset stall", 64'(stall), 64'd0);
      check("reset branch_taken", 64'(branch_taken), 64'd0);
      rst = 1'b0;

      // ADDI R1 = R0 + 5
      step(16'h9205, 3'd0, 1'b0, 8'd0);
      step(16'h0000, 3'd0, 1'b0, 8'd0);
      check("addi val1", 64'(id_ex_val1), 64'd0);
      check("addi val2", 64'(id_ex_val2), 64'd5);
      check("addi dest", 64'(id_ex_dest), 64'd1);
      check("addi reg_write", 64'(id_ex_reg_write), 64'd1);

      // LD R7 <- [R3+14] followed by ADD R3 = R6 + R7
      step(16'hAECE, 3'd0, 1'b0, 8'd0);
      step(16'h17B8, 3'd0, 1'b0, 8'd0);
      step(16'h0000, 3'd0, 1'b0, 8'd0);
      check("load-use stall", 64'(s_stall), 64'd1);
      check("load-use bubble", 64'(dut_ex()), 64'd0);
      step(16'h0000, 3'd0, 1'b0, 8'd0);
      check("load-use released", 64'(s_stall), 64'd0);
      check("add issued alu_op", 64'(id_ex_alu_op), 64'd1);
      check("add issued dest", 64'(id_ex_dest), 64'd3);

      // BR R1,+1 with R1 == 0: taken, the following ADDI is flushed
      step(16'hC041, 3'd0, 1'b0, 8'd0);
      step(16'h9205, 3'd0, 1'b0, 8'd0);
      check("br taken", 64'(s_bt), 64'd1);
      check("br offset", 64'(s_off), 64'h01);
      check("br bubble", 64'(dut_ex()), 64'd0);
      step(16'h0000, 3'd0, 1'b0, 8'd0);
      check("flushed reg_write", 64'(id_ex_reg_write), 64'd0);

      // R1 = 1, then BR R1,-5: not taken, no flush
      step(16'h0000, 3'd1, 1'b1, 8'd1);
      step(16'hC07B, 3'd0, 1'b0, 8'd0);
      step(16'h9205, 3'd0, 1'b0, 8'd0);
      check("br not taken", 64'(s_bt), 64'd0);
      check("br offset -5", 64'(s_off), 64'h3B);
      step(16'h0000, 3'd0, 1'b0, 8'd0);
      check("no flush reg_write", 64'(id_ex_reg_write), 64'd1);

      // Write R0 = 7, then ADD R4 = R0 + R0
      step(16'h0000, 3'd0, 1'b1, 8'd7);
      step(16'h1800, 3'd0, 1'b0, 8'd0);
      step(16'h0000, 3'd0, 1'b0, 8'd0);
      check("r0 hard zero", 64'(id_ex_val1), 64'd0);

      // ADD R4 = R2 + R0 while WB writes R2 = -5 in the same cycle
      step(16'h1880, 3'd0, 1'b0, 8'd0);
      step(16'h0000, 3'd2, 1'b1, 8'hFB);
`ifdef ID_RF_BYPASS_EN
      check("bypass val1", 64'(id_ex_val1), 64'hFB);
`else
      check("no-bypass val1", 64'(id_ex_val1), 64'h00);
`endif

      // Reset asserted in the middle of a load-use stall
      step(16'hAECE, 3'd0, 1'b0, 8'd0);
      step(16'h17B8, 3'd0, 1'b0, 8'd0);
      if_instr = 16'h0000;
      wb_we = 1'b0;
      #2;
      check("pre-reset stall", 64'(stall), 64'd1);
      rst = 1'b1;
      #1;
      check("mid reset stall", 64'(stall), 64'd0);
      check("mid reset id_ex", 64'(dut_ex()), 64'd0);
      check("mid reset branch_taken", 64'(branch_taken), 64'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      step(16'h9205, 3'd0, 1'b0, 8'd0);
      step(16'h0000, 3'd0, 1'b0, 8'd0);
      check("post-reset dest", 64'(id_ex_dest), 64'd1);
      check("post-reset val2", 64'(id_ex_val2), 64'd5);

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         logic [15:0] ins;
         ins = 16'($urandom);
         if ($urandom_range(0, 3) == 0) ins[15:12] = 4'(12);
         step(ins, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 16-bit, 8-register pipelined core. It sits directly downstream of the fetch stage. It holds the IF/ID pipeline register, the 8×8-bit register file, branch resolution and load-use/branch hazard detection, and it drives the ID/EX pipeline register consumed by the execute stage. It returns `stall`, `branch_taken` and `branch_offset_imm` to fetch.

## Interface
Parameters:
- `DW`, 8: register/data width.
- `PCW`, 8: PC width.

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `if_pc`  in  PCW  PC of the instruction presented by fetch.
- `if_instr`  in  16  instruction fetched at `if_pc`.
- `wb_we`  in  1  writeback enable.
- `wb_dest`  in  3  writeback register.
- `wb_data`  in  DW  writeback value.
- `stall`  out  1  combinational; freezes fetch PC and IF/ID.
- `branch_taken`  out  1  combinational; branch resolved taken in ID.
- `branch_offset_imm`  out  6  combinational; `instr[5:0]` of the ID instruction.
- `id_ex_alu_op`  out  4  registered ALU opcode.
- `id_ex_val1`  out  DW  registered operand A.
- `id_ex_val2`  out  DW  registered operand B.
- `id_ex_st_data`  out  DW  registered store data.
- `id_ex_dest`  out  3  registered destination register.
- `id_ex_reg_write`  out  1  registered control.
- `id_ex_mem_read`  out  1  registered control.
- `id_ex_mem_write`  out  1  registered control.

## Operation
Instruction fields:
- `op=[15:12]`, `rd=[11:9]`, `rs1=[8:6]`, `rs2=[5:3]`, `imm=[5:0]`.
- `imm` is sign-extended to DW.

Opcodes:
- 0 NOP.
- 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SL, 7 SR: operands `rs1`, `rs2`.
- 9 ADDI: `val2=sext(imm)`; `alu_op` = ADD.
- 10 LD: `rd` ← Mem[R[rs1]+sext(imm)]; `alu_op` = ADD; `mem_read=1`.
- 11 ST: Mem[R[rs1]+sext(imm)] ← R[rd]; `alu_op` = ADD; `st_data=R[rd]`; `mem_write=1`; `reg_write=0`.
- 12 BR: taken when R[rs1]==0.
- Any other opcode decodes as NOP.

Register file:
- R0 always reads 0; writes to R0 are ignored.
- Writes occur on the clock edge when `wb_we`.
- Two read ports serve `rs1` and `rs2`/`rd`; reads are combinational.

Hazard detection (`stall=1`), based on the instruction currently in ID/EX:
- Load-use: ID/EX has `mem_read=1`, its `dest`≠0, and `dest` equals any source the ID instruction uses.
- Branch operand: the ID instruction is BR, ID/EX has `reg_write=1`, its `dest`≠0, and `dest`==`rs1`.
- Sources used per opcode: ALU ops use `rs1`,`rs2`; ADDI/LD use `rs1`; ST uses `rs1`,`rd`; BR uses `rs1`.

Branch:
- `branch_taken = (op==BR) && R[rs1]==0 && !stall`.
- BR never enters EX; ID/EX receives a bubble.

IF/ID register update, in priority order:
- `rst` → instruction = NOP, pc = 0.
- `stall` → hold.
- `branch_taken` → load NOP (flush the wrong-path instruction).
- Otherwise load `if_instr`/`if_pc`.

ID/EX register update:
- Loads a bubble (all controls 0, data 0, `alu_op`=0) on stall, BR, or NOP.
- Otherwise loads the decoded values.

## Timing
- Reset: every output register is 0. IF/ID holds NOP. All registers R0–R7 are 0. `stall`=0 and `branch_taken`=0 while in reset.
- Latency: an instruction captured into IF/ID at edge N appears on `id_ex_*` after edge N+1.
- A load-use stall lasts exactly 1 cycle.
- A branch-operand stall lasts 1 cycle.
- `stall` and `branch_taken` are mutually exclusive by construction.
- Asserting reset mid-operation clears both pipeline registers immediately (asynchronously). The register file also clears.

## Configuration
- `ID_RF_BYPASS_EN` defined: a WB write to a register that ID reads in the same cycle returns `wb_data`. This applies to all read ports and to the branch compare.
- `ID_RF_BYPASS_EN` undefined: the read returns the old value. Software must then schedule a NOP between the producing and consuming instructions.

## Structure
- Package `id_pkg`:
  - opcode constants (`OP_NOP`…`OP_BR`);
  - field bit positions;
  - the `NOP` instruction constant;
  - ALU-op encoding shared with the EX stage.
- Sub-module `reg_file`: 8×DW, R0 hard-zero, 2 read ports, 1 write port, with the bypass under `ID_RF_BYPASS_EN`.

## Test plan
- Reset, then ADDI R1=5 (`1001001000000101`) → two edges later `id_ex_val1`=0, `id_ex_val2`=5, `id_ex_dest`=1, `id_ex_reg_write`=1.
- LD R7 ← [R3+14], followed by ADD R3=R6+R7 → `stall`=1 for exactly one cycle; a bubble enters ID/EX; the ADD issues next cycle.
- R1=0, then BR R1,+1 (`1100000001000001`) → `branch_taken`=1 and `branch_offset_imm`=6'b000001; next IF/ID = NOP; ID/EX receives a bubble.
- R1=1, then BR R1,−5 → `branch_taken`=0 and no flush.
- With bypass enabled: WB writes R2=−5 in the same cycle ID reads R2 → operand = 8'hFB. Writing R0=7 → R0 still reads 0.
- Assert `rst` mid-stall → outputs are 0 and `stall`=0 immediately; normal fetch resumes after reset deasserts.
